lsu_prefetch_gen: RTL and testbench
===================================

# lsu_prefetch_gen

Request-path stage directly upstream of the LSU unit: consumes LSU requests from dispatch and drives the LSU request bundle, including `is_prefetch`. Every demand load is forwarded unchanged, then followed by up to `PF_LINES` next-line prefetch requests with `is_prefetch=1` and `wb=0`. Stores, fences and incoming prefetches pass through without generating prefetches. The block holds one output register and a small issue FSM.

## Interface
- `LINE_SIZE`, 64: cache line bytes; power of two, 4..4096.
- `PF_LINES`, 2: prefetches per demand load, 1..4.
- `clk` in 1: clock.
- `reset` in 1: asynchronous, active-low reset.
- `in_valid` in 1, `in_ready` out 1: upstream handshake.
- `in_wid` in `NW_BITS`; `in_tmask` in `NUM_THREADS`; `in_PC` in 32; `in_op_type` in `INST_LSU_BITS`; `in_is_fence` in 1; `in_store_data` in `NUM_THREADS*32`; `in_base_addr` in `NUM_THREADS*32`; `in_offset` in 32; `in_rd` in `NR_BITS`; `in_wb` in 1; `in_is_prefetch` in 1.
- `out_valid` out 1, `out_ready` in 1: LSU handshake.
- `out_wid`, `out_tmask`, `out_PC`, `out_op_type`, `out_is_fence`, `out_store_data`, `out_base_addr`, `out_offset`, `out_rd`, `out_wb`, `out_is_prefetch` out: same widths as the inputs.
- `pf_count` out 16: saturating count of issued prefetches.

## Operation
- Demand load: `in_valid & ~in_is_fence & ~in_is_prefetch & ~in_op_type[INST_LSU_BITS-1]`.
- States:
  - IDLE: `in_ready = ~out_valid | out_ready`. A handshake loads the request into the output register. A demand load also latches wid, tmask, PC, op_type, and per-thread line base `L[i] = (base_addr[i]+offset) & ~(LINE_SIZE-1)`, sets `k=1`, and moves to PF.
  - PF: `in_ready=0`. When the output register is empty or being drained, load prefetch k:
    - `base_addr[i] = L[i] + k*LINE_SIZE` (mod 2^32); `offset=0`.
    - `is_prefetch=1`, `wb=0`, `rd=0`, `is_fence=0`, `store_data=0`.
    - wid, tmask, PC and op_type copied from the latch.
    - Increment k; after `k==PF_LINES` is loaded, return to IDLE.
- Output register holds its value while `out_valid & ~out_ready` (no field changes while stalled).
- Non-load requests, including incoming prefetches, pass through with their `is_prefetch` preserved. They never enter PF.
- `pf_count` increments on each out handshake with `out_is_prefetch=1`; saturates at 0xFFFF.
- Reset (any time, including mid-PF): `out_valid=0`, all out fields 0, state IDLE, `k=0`, `pf_count=0`. `in_ready=1` once reset is released. Any pending prefetches are discarded.

## Timing
- Latency 1: input accepted at edge N gives `out_valid` after edge N, held until `out_ready`.
- Full throughput: with `out_ready=1` held, one request per cycle in IDLE.
- A demand load occupies `1+PF_LINES` output cycles. Prefetch k is presented the cycle after prefetch k-1 (or the demand) handshakes.
- `in_ready` is combinational from state, `out_valid` and `out_ready`. No other combinational in-to-out paths.
- Back-to-back loads: the second load is accepted only in the cycle the last prefetch of the first load handshakes.

## Configuration
- `LSU_PF_DROP_EN` defined:
  - In PF, `in_ready = ~out_valid | out_ready` as in IDLE.
  - If `in_valid` is seen there, remaining prefetches are abandoned; the new request is accepted and handled as in IDLE.
  - The prefetch already held in the output register is still delivered.
- Undefined: all `PF_LINES` prefetches always issue before a new request is accepted.

## Test plan
- LINE_SIZE=64, PF_LINES=2; load with base 0x1000, offset 0x10, `out_ready=1` -> cycle 1 demand (base 0x1000, offset 0x10, wb as given); cycle 2 prefetch base 0x1040; cycle 3 prefetch base 0x1080, `wb=0`, `is_prefetch=1`; `pf_count=2`.
- Wrap: base 0xFFFFFFC8, offset 0x8 -> prefetches base 0x00000000 and 0x00000040.
- Store (op_type MSB=1) followed by a fence, `out_ready=1` -> both emitted 1 cycle after accept; no prefetches; `pf_count` unchanged.
- `out_ready` low for 5 cycles while prefetch 1 is pending -> outputs stable; `in_ready=0`; prefetch 2 follows exactly one cycle after release.
- Reset asserted mid-PF after the first prefetch -> `out_valid=0` immediately; after release, a new load issues a demand plus 2 prefetches with no leftover prefetch.
- `LSU_PF_DROP_EN`: load followed by a store presented during PF -> output sequence is demand, prefetch 1, store. Without the macro -> demand, prefetch 1, prefetch 2, store.

Source files
------------

// File: rtl/lsu_prefetch_gen.sv
// LSU request stage that forwards dispatch requests and follows each demand load
// with PF_LINES next-line prefetches. Optional feature macro: LSU_PF_DROP_EN.
module lsu_prefetch_gen #(
    parameter int LINE_SIZE     = 64,
    parameter int PF_LINES      = 2,
    parameter int NUM_THREADS   = 4,
    parameter int NW_BITS       = 2,
    parameter int INST_LSU_BITS = 4,
    parameter int NR_BITS       = 5
) (
    input  logic                       clk,
    input  logic                       reset,

    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [NW_BITS-1:0]         in_wid,
    input  logic [NUM_THREADS-1:0]     in_tmask,
    input  logic [31:0]                in_PC,
    input  logic [INST_LSU_BITS-1:0]   in_op_type,
    input  logic                       in_is_fence,
    input  logic [NUM_THREADS*32-1:0]  in_store_data,
    input  logic [NUM_THREADS*32-1:0]  in_base_addr,
    input  logic [31:0]                in_offset,
    input  logic [NR_BITS-1:0]         in_rd,
    input  logic                       in_wb,
    input  logic                       in_is_prefetch,

    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [NW_BITS-1:0]         out_wid,
    output logic [NUM_THREADS-1:0]     out_tmask,
    output logic [31:0]                out_PC,
    output logic [INST_LSU_BITS-1:0]   out_op_type,
    output logic                       out_is_fence,
    output logic [NUM_THREADS*32-1:0]  out_store_data,
    output logic [NUM_THREADS*32-1:0]  out_base_addr,
    output logic [31:0]                out_offset,
    output logic [NR_BITS-1:0]         out_rd,
    output logic                       out_wb,
    output logic                       out_is_prefetch,

    output logic [15:0]                pf_count
);

    localparam int          LINE_SHIFT = $clog2(LINE_SIZE);
    localparam logic [31:0] LINE_MASK  = ~(32'(LINE_SIZE) - 32'd1);
    localparam logic [2:0]  K_LAST     = 3'(PF_LINES);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_PF   = 1'b1;

    logic [0:0]                 state;
    logic [2:0]                 k;
    logic [NW_BITS-1:0]         lat_wid;
    logic [NUM_THREADS-1:0]     lat_tmask;
    logic [31:0]                lat_pc;
    logic [INST_LSU_BITS-1:0]   lat_op_type;
    logic [NUM_THREADS*32-1:0]  lat_line;

    logic                       load_en;
    logic                       in_fire;
    logic                       is_demand;
    logic                       out_fire;
    logic [31:0]                k_step;
    logic [NUM_THREADS*32-1:0]  line_base;
    logic [NUM_THREADS*32-1:0]  pf_base;

    assign load_en   = ~out_valid | out_ready;
    assign out_fire  = out_valid & out_ready;
    assign is_demand = in_valid & ~in_is_fence & ~in_is_prefetch & ~in_op_type[INST_LSU_BITS-1];

`ifdef LSU_PF_DROP_EN
    // A new request may cut the prefetch burst short; only the register contents survive.
    assign in_ready = load_en;
`else
    assign in_ready = (state == S_IDLE) & load_en;
`endif

    assign in_fire = in_valid & in_ready;
    assign k_step  = 32'(k) << LINE_SHIFT;

    always_comb begin
        line_base = '0;
        pf_base   = '0;
        for (int i = 0; i < NUM_THREADS; i++) begin
            line_base[i*32 +: 32] = (in_base_addr[i*32 +: 32] + in_offset) & LINE_MASK;
            pf_base[i*32 +: 32]   = lat_line[i*32 +: 32] + k_step;
        end
    end

    // Output register and issue FSM: an accepted request always wins over a pending prefetch.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state           <= S_IDLE;
            k               <= '0;
            lat_wid         <= '0;
            lat_tmask       <= '0;
            lat_pc          <= '0;
            lat_op_type     <= '0;
            lat_line        <= '0;
            out_valid       <= 1'b0;
            out_wid         <= '0;
            out_tmask       <= '0;
            out_PC          <= '0;
            out_op_type     <= '0;
            out_is_fence    <= 1'b0;
            out_store_data  <= '0;
            out_base_addr   <= '0;
            out_offset      <= '0;
            out_rd          <= '0;
            out_wb          <= 1'b0;
            out_is_prefetch <= 1'b0;
        end else if (in_fire) begin
            out_valid       <= 1'b1;
            out_wid         <= in_wid;
            out_tmask       <= in_tmask;
            out_PC          <= in_PC;
            out_op_type     <= in_op_type;
            out_is_fence    <= in_is_fence;
            out_store_data  <= in_store_data;
            out_base_addr   <= in_base_addr;
            out_offset      <= in_offset;
            out_rd          <= in_rd;
            out_wb          <= in_wb;
            out_is_prefetch <= in_is_prefetch;
            if (is_demand) begin
                state       <= S_PF;
                k           <= 3'd1;
                lat_wid     <= in_wid;
                lat_tmask   <= in_tmask;
                lat_pc      <= in_PC;
                lat_op_type <= in_op_type;
                lat_line    <= line_base;
            end else begin
                state <= S_IDLE;
                k     <= '0;
            end
        end else if ((state == S_PF) && load_en) begin
            out_valid       <= 1'b1;
            out_wid         <= lat_wid;
            out_tmask       <= lat_tmask;
            out_PC          <= lat_pc;
            out_op_type     <= lat_op_type;
            out_is_fence    <= 1'b0;
            out_store_data  <= '0;
            out_base_addr   <= pf_base;
            out_offset      <= '0;
            out_rd          <= '0;
            out_wb          <= 1'b0;
            out_is_prefetch <= 1'b1;
            if (k == K_LAST) begin
                state <= S_IDLE;
                k     <= '0;
            end else begin
                k <= k + 3'd1;
            end
        end else if (out_fire) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pf_count <= '0;
        end else if (out_fire && out_is_prefetch && (pf_count != 16'hFFFF)) begin
            pf_count <= pf_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_lsu_prefetch_gen.sv
// Directed bench for lsu_prefetch_gen; expected sequence adapts to LSU_PF_DROP_EN.
module tb_lsu_prefetch_gen;

    logic         clk;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [1:0]   in_wid;
    logic [3:0]   in_tmask;
    logic [31:0]  in_PC;
    logic [3:0]   in_op_type;
    logic         in_is_fence;
    logic [127:0] in_store_data;
    logic [127:0] in_base_addr;
    logic [31:0]  in_offset;
    logic [4:0]   in_rd;
    logic         in_wb;
    logic         in_is_prefetch;
    logic         out_valid;
    logic         out_ready;
    logic [1:0]   out_wid;
    logic [3:0]   out_tmask;
    logic [31:0]  out_PC;
    logic [3:0]   out_op_type;
    logic         out_is_fence;
    logic [127:0] out_store_data;
    logic [127:0] out_base_addr;
    logic [31:0]  out_offset;
    logic [4:0]   out_rd;
    logic         out_wb;
    logic         out_is_prefetch;
    logic [15:0]  pf_count;

    int total_checks;
    int bad_checks;

    localparam logic [127:0] SD      = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
    localparam logic [3:0]   OP_LOAD = 4'b0010;
    localparam logic [3:0]   OP_STORE = 4'b1001;

    lsu_prefetch_gen #(
        .LINE_SIZE(64), .PF_LINES(2), .NUM_THREADS(4),
        .NW_BITS(2), .INST_LSU_BITS(4), .NR_BITS(5)
    ) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_wid(in_wid), .in_tmask(in_tmask), .in_PC(in_PC), .in_op_type(in_op_type),
        .in_is_fence(in_is_fence), .in_store_data(in_store_data), .in_base_addr(in_base_addr),
        .in_offset(in_offset), .in_rd(in_rd), .in_wb(in_wb), .in_is_prefetch(in_is_prefetch),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_wid(out_wid), .out_tmask(out_tmask), .out_PC(out_PC), .out_op_type(out_op_type),
        .out_is_fence(out_is_fence), .out_store_data(out_store_data), .out_base_addr(out_base_addr),
        .out_offset(out_offset), .out_rd(out_rd), .out_wb(out_wb), .out_is_prefetch(out_is_prefetch),
        .pf_count(pf_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Threads 1..3 sit 0x100 apart from thread 0, so each lands on its own line.
    function automatic logic [127:0] spread(input logic [31:0] x);
        return {x + 32'h300, x + 32'h200, x + 32'h100, x};
    endfunction

    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total_checks++;
        if (obs !== exp) begin
            bad_checks++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [3:0] op, input logic fence,
                                 input logic pf, input logic [31:0] base, input logic [31:0] off,
                                 input logic wb, input logic [4:0] rd, input logic [31:0] pc);
        in_valid       = v;
        in_wid         = 2'd1;
        in_tmask       = 4'b1011;
        in_PC          = pc;
        in_op_type     = op;
        in_is_fence    = fence;
        in_is_prefetch = pf;
        in_store_data  = SD;
        in_base_addr   = spread(base);
        in_offset      = off;
        in_wb          = wb;
        in_rd          = rd;
    endtask

    task automatic idleInput();
        applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    task automatic checkDemand(input string tag, input logic [31:0] base, input logic [31:0] off,
                               input logic [31:0] pc);
        checkOutput({tag, ".valid"}, 128'(out_valid), 128'd1);
        checkOutput({tag, ".is_pf"}, 128'(out_is_prefetch), 128'd0);
        checkOutput({tag, ".base"}, out_base_addr, spread(base));
        checkOutput({tag, ".offset"}, 128'(out_offset), 128'(off));
        checkOutput({tag, ".wb"}, 128'(out_wb), 128'd1);
        checkOutput({tag, ".rd"}, 128'(out_rd), 128'd5);
        checkOutput({tag, ".pc"}, 128'(out_PC), 128'(pc));
        checkOutput({tag, ".sdata"}, out_store_data, SD);
    endtask

    task automatic checkPrefetch(input string tag, input logic [31:0] base, input logic [31:0] pc);
        checkOutput({tag, ".valid"}, 128'(out_valid), 128'd1);
        checkOutput({tag, ".is_pf"}, 128'(out_is_prefetch), 128'd1);
        checkOutput({tag, ".base"}, out_base_addr, spread(base));
        checkOutput({tag, ".offset"}, 128'(out_offset), 128'd0);
        checkOutput({tag, ".wb"}, 128'(out_wb), 128'd0);
        checkOutput({tag, ".rd"}, 128'(out_rd), 128'd0);
        checkOutput({tag, ".fence"}, 128'(out_is_fence), 128'd0);
        checkOutput({tag, ".sdata"}, out_store_data, 128'd0);
        checkOutput({tag, ".wid"}, 128'(out_wid), 128'd1);
        checkOutput({tag, ".tmask"}, 128'(out_tmask), 128'hB);
        checkOutput({tag, ".pc"}, 128'(out_PC), 128'(pc));
        checkOutput({tag, ".op"}, 128'(out_op_type), 128'(OP_LOAD));
    endtask

    initial begin
        total_checks = 0;
        bad_checks   = 0;
        reset        = 1'b0;
        out_ready    = 1'b1;
        idleInput();
        repeat (2) @(negedge clk);
        checkOutput("rst.valid", 128'(out_valid), 128'd0);
        checkOutput("rst.base", out_base_addr, 128'd0);
        checkOutput("rst.count", 128'(pf_count), 128'd0);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("rst.in_ready", 128'(in_ready), 128'd1);

        // Basic demand load plus two next-line prefetches
        applyStimulus(1'b1, OP_LOAD, 1'b0, 1'b0, 32'h1000, 32'h10, 1'b1, 5'd5, 32'h400);
        @(negedge clk);
        checkDemand("t1.dem", 32'h1000, 32'h10, 32'h400);
        checkOutput("t1.dem.in_ready", 128'(in_ready), 128'd0);
        idleInput();
        @(negedge clk);
        checkPrefetch("t1.pf1", 32'h1040, 32'h400);
        checkOutput("t1.pf1.in_ready", 128'(in_ready), 128'd0);
        @(negedge clk);
        checkPrefetch("t1.pf2", 32'h1080, 32'h400);
        checkOutput("t1.pf2.in_ready", 128'(in_ready), 128'd1);
        @(negedge clk);
        checkOutput("t1.end.valid", 128'(out_valid), 128'd0);
        checkOutput("t1.count", 128'(pf_count), 128'd2);

        // Address wrap past 2^32
        applyStimulus(1'b1, OP_LOAD, 1'b0, 1'b0, 32'hFFFFFFC8, 32'h8, 1'b1, 5'd5, 32'h500);
        @(negedge clk);
        checkDemand("t2.dem", 32'hFFFFFFC8, 32'h8, 32'h500);
        idleInput();
        @(negedge clk);
        checkPrefetch("t2.pf1", 32'h0000_0000, 32'h500);
        @(negedge clk);
        checkPrefetch("t2.pf2", 32'h0000_0040, 32'h500);
        @(negedge clk);
        checkOutput("t2.end.valid", 128'(out_valid), 128'd0);
        checkOutput("t2.count", 128'(pf_count), 128'd4);

        // Store, fence and an incoming prefetch pass through untouched
        applyStimulus(1'b1, OP_STORE, 1'b0, 1'b0, 32'h2000, 32'h4, 1'b0, 5'd0, 32'h600);
        @(negedge clk);
        checkOutput("t3.st.valid", 128'(out_valid), 128'd1);
        checkOutput("t3.st.op", 128'(out_op_type), 128'(OP_STORE));
        checkOutput("t3.st.base", out_base_addr, spread(32'h2000));
        checkOutput("t3.st.sdata", out_store_data, SD);
        checkOutput("t3.st.in_ready", 128'(in_ready), 128'd1);
        applyStimulus(1'b1, OP_LOAD, 1'b1, 1'b0, 32'h2100, 32'h0, 1'b0, 5'd0, 32'h604);
        @(negedge clk);
        checkOutput("t3.fn.valid", 128'(out_valid), 128'd1);
        checkOutput("t3.fn.fence", 128'(out_is_fence), 128'd1);
        checkOutput("t3.fn.pc", 128'(out_PC), 128'h604);
        applyStimulus(1'b1, OP_LOAD, 1'b0, 1'b1, 32'h2200, 32'h0, 1'b0, 5'd0, 32'h608);
        @(negedge clk);
        checkOutput("t3.ipf.valid", 128'(out_valid), 128'd1);
        checkOutput("t3.ipf.is_pf", 128'(out_is_prefetch), 128'd1);
        checkOutput("t3.ipf.base", out_base_addr, spread(32'h2200));
        checkOutput("t3.ipf.count", 128'(pf_count), 128'd4);
        idleInput();
        @(negedge clk);
        checkOutput("t3.end.valid", 128'(out_valid), 128'd0);
        checkOutput("t3.count", 128'(pf_count), 128'd5);

        // Back-pressure while prefetch 1 is held
        applyStimulus(1'b1, OP_LOAD, 1'b0, 1'b0, 32'h3000, 32'h0, 1'b1, 5'd5, 32'h700);
        @(negedge clk);
        checkDemand("t4.dem", 32'h3000, 32'h0, 32'h700);
        idleInput();
        @(negedge clk);
        checkPrefetch("t4.pf1", 32'h3040, 32'h700);
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkPrefetch("t4.stall", 32'h3040, 32'h700);
            checkOutput("t4.stall.in_ready", 128'(in_ready), 128'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        checkPrefetch("t4.pf2", 32'h3080, 32'h700);
        @(negedge clk);
        checkOutput("t4.end.valid", 128'(out_valid), 128'd0);
        checkOutput("t4.count", 128'(pf_count), 128'd7);

        // Reset in the middle of a prefetch burst
        applyStimulus(1'b1, OP_LOAD, 1'b0, 1'b0, 32'h4000, 32'h0, 1'b1, 5'd5, 32'h800);
        @(negedge clk);
        idleInput();
        @(negedge clk);
        checkPrefetch("t5.pf1", 32'h4040, 32'h800);
        reset = 1'b0;
        #1;
        checkOutput("t5.rst.valid", 128'(out_valid), 128'd0);
        checkOutput("t5.rst.base", out_base_addr, 128'd0);
        checkOutput("t5.rst.count", 128'(pf_count), 128'd0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        checkOutput("t5.rel.in_ready", 128'(in_ready), 128'd1);
        applyStimulus(1'b1, OP_LOAD, 1'b0, 1'b0, 32'h5000, 32'h0, 1'b1, 5'd5, 32'h900);
        @(negedge clk);
        checkDemand("t5.dem", 32'h5000, 32'h0, 32'h900);
        idleInput();
        @(negedge clk);
        checkPrefetch("t5.pf1b", 32'h5040, 32'h900);
        @(negedge clk);
        checkPrefetch("t5.pf2b", 32'h5080, 32'h900);
        @(negedge clk);
        checkOutput("t5.end.valid", 128'(out_valid), 128'd0);
        checkOutput("t5.count", 128'(pf_count), 128'd2);

        // Store arriving while prefetch 1 sits in the output register
        applyStimulus(1'b1, OP_LOAD, 1'b0, 1'b0, 32'h6000, 32'h0, 1'b1, 5'd5, 32'hA00);
        @(negedge clk);
        checkDemand("t6.dem", 32'h6000, 32'h0, 32'hA00);
        idleInput();
        @(negedge clk);
        checkPrefetch("t6.pf1", 32'h6040, 32'hA00);
        applyStimulus(1'b1, OP_STORE, 1'b0, 1'b0, 32'h7000, 32'h0, 1'b0, 5'd0, 32'hA10);
`ifndef LSU_PF_DROP_EN
        checkOutput("t6.pf1.in_ready", 128'(in_ready), 128'd0);
        @(negedge clk);
        checkPrefetch("t6.pf2", 32'h6080, 32'hA00);
`endif
        @(negedge clk);
        checkOutput("t6.st.valid", 128'(out_valid), 128'd1);
        checkOutput("t6.st.is_pf", 128'(out_is_prefetch), 128'd0);
        checkOutput("t6.st.op", 128'(out_op_type), 128'(OP_STORE));
        checkOutput("t6.st.base", out_base_addr, spread(32'h7000));
        idleInput();
        @(negedge clk);
        checkOutput("t6.end.valid", 128'(out_valid), 128'd0);
`ifdef LSU_PF_DROP_EN
        checkOutput("t6.count", 128'(pf_count), 128'd3);
`else
        checkOutput("t6.count", 128'(pf_count), 128'd4);
`endif

        $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
        $finish;
    end

endmodule
